wav_ahb_csr_cmd_master: RTL and testbench
=========================================

// Module: wav_ahb_csr_cmd_master
// PURPOSE
//  Single-outstanding AHB-Lite master that turns a valid/ready command stream into AHB single transfers.
//  Drives the MCU-top CSR AHB slave port (haddr/hwrite/hsel/hwdata/htrans/hsize/hburst).
//  Returns read data and error/slow status on a valid/ready response stream.
//  Used by bring-up/test hosts to access CSRs without the core.
// PARAMETERS
//  AWIDTH   32  address width, matches the CSR slave
//  DWIDTH   32  data width, matches the CSR slave
//  TIMEOUT  16  data-phase wait cycles before the stall flag asserts, range 1..255
// PORTS
//  i_hclk         in   1       clock, the only clock
//  i_hreset       in   1       synchronous, active-high reset
//  i_cmd_valid    in   1       command valid
//  o_cmd_ready    out  1       command accepted when valid&ready
//  i_cmd_write    in   1       1=write, 0=read
//  i_cmd_addr     in   AWIDTH  byte address, word aligned
//  i_cmd_wdata    in   DWIDTH  write data (ignored for reads)
//  o_rsp_valid    out  1       response valid
//  i_rsp_ready    in   1       response consumed when valid&ready
//  o_rsp_rdata    out  DWIDTH  read data; 0 for writes and errors
//  o_rsp_error    out  1       slave returned non-OKAY hresp
//  o_rsp_slow     out  1       data phase reached TIMEOUT wait cycles
//  o_stall        out  1       level: current data phase waited >= TIMEOUT cycles
//  o_haddr        out  AWIDTH  AHB address
//  o_hwrite       out  1       AHB write
//  o_hsel         out  1       AHB select
//  o_hwdata       out  DWIDTH  AHB write data
//  o_htrans       out  2       AHB trans: 2'b00 IDLE, 2'b10 NONSEQ
//  o_hsize        out  3       constant 3'b010 (word)
//  o_hburst       out  3       constant 3'b000 (SINGLE)
//  i_hready       in   1       slave hready; also looped to slave hreadyin at top level
//  i_hrdata       in   DWIDTH  slave read data
//  i_hresp        in   2       slave response, 2'b00=OKAY
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except o_cmd_ready=1, o_hsize=3'b010, o_hburst=3'b000.
//  - Reset mid-operation: the next cycle is IDLE. Pending response is dropped. o_htrans/o_hsel=0.
//  - All outputs are registered. No combinational path from inputs to outputs.
//  - FSM IDLE->ADDR->DATA->RSP->IDLE:
//    IDLE: o_cmd_ready=1. On valid&ready, register write, addr and wdata; go to ADDR.
//    ADDR: o_hsel=1, o_htrans=NONSEQ, o_haddr/o_hwrite driven.
//          Hold until i_hready=1, then go to DATA.
//    DATA: o_htrans=IDLE, o_hsel=0, o_hwdata=wdata (writes), address held.
//          Wait-cycle counter increments each cycle i_hready=0 and saturates at 255.
//          o_stall=1 once counter>=TIMEOUT. On i_hready=1, capture i_hrdata (read & OKAY) and hresp status; go to RSP.
//    RSP:  o_rsp_valid=1, fields stable until i_rsp_ready. On handshake, clear o_stall and the counter; go to IDLE.
//  - Error: any i_hresp!=2'b00 sampled with i_hready=1 in DATA -> o_rsp_error=1, o_rsp_rdata=0.
//    The first ERROR cycle (hready=0, hresp=01) only counts as a wait cycle.
//  - No abort: a stalled transfer is never abandoned. o_rsp_slow=1 is latched if o_stall was set.
//  - Minimum latency with a zero-wait slave: accept at cycle 0, ADDR at 1, DATA at 2, o_rsp_valid at 3.
//    Minimum throughput: one command per 4 cycles. o_cmd_ready=0 outside IDLE.
//  - i_cmd_* are ignored when o_cmd_ready=0. Address bits [1:0] are passed unchanged.
// TESTING
//  - Write addr 0x0000_0004, data 0xA5A5_1234, zero-wait slave -> NONSEQ/hwrite=1 at c1, hwdata=0xA5A5_1234 at c2, rsp_valid at c3, error=0, rdata=0.
//  - Read 0x0000_0008, slave holds hready low 3 DATA cycles then hrdata=0xDEAD_BEEF -> rsp_valid at c6, rdata=0xDEAD_BEEF, slow=0.
//  - Read, slave ERROR (hresp=01 with hready 0 then 1) -> rsp_error=1, rdata=0, back to IDLE after handshake.
//  - TIMEOUT=4, slave hready low 10 cycles -> o_stall rises on the 4th wait cycle; rsp at completion has slow=1; o_stall clears after handshake.
//  - i_rsp_ready low 5 cycles at RSP -> response held bit-stable, o_cmd_ready=0, new i_cmd_valid ignored until handshake.
//  - i_hreset pulsed during DATA -> next cycle all outputs at reset values, no rsp_valid; next command runs normally.

Source files
------------

// File: rtl/wav_ahb_csr_cmd_master.sv
// wav_ahb_csr_cmd_master
// Single-outstanding AHB-Lite master that turns a valid/ready command stream
// into AHB SINGLE word transfers on the CSR slave port. It returns read data
// and error/slow status on a valid/ready response stream.
// Every output comes from a flop, so no input reaches an output in the same cycle.
module wav_ahb_csr_cmd_master #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16   // data-phase wait cycles before o_stall, 1..255
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    // command stream
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [AWIDTH-1:0] i_cmd_addr,
    input  logic [DWIDTH-1:0] i_cmd_wdata,
    // response stream
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_rsp_slow,
    output logic              o_stall,
    // AHB-Lite master port
    output logic [AWIDTH-1:0] o_haddr,
    output logic              o_hwrite,
    output logic              o_hsel,
    output logic [DWIDTH-1:0] o_hwdata,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    input  logic              i_hready,
    input  logic [DWIDTH-1:0] i_hrdata,
    input  logic [1:0]        i_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [7:0] TIMEOUT_C     = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        wait_cnt_q;
    logic [7:0]        wait_cnt_d;
    logic [DWIDTH-1:0] wdata_q;

    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_error_q;
    logic              rsp_slow_q;
    logic              stall_q;
    logic [AWIDTH-1:0] haddr_q;
    logic              hwrite_q;
    logic              hsel_q;
    logic [DWIDTH-1:0] hwdata_q;
    logic [1:0]        htrans_q;

    // Saturating increment of the data-phase wait counter (sticks at 255).
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Transfer FSM IDLE->ADDR->DATA->RSP with all outputs registered.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            rsp_slow_q  <= 1'b0;
            stall_q     <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsel_q      <= 1'b0;
            hwdata_q    <= '0;
            htrans_q    <= HTRANS_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // o_cmd_ready is high here, so valid alone completes the handshake.
                    if (i_cmd_valid) begin
                        hwrite_q    <= i_cmd_write;
                        haddr_q     <= i_cmd_addr;
                        wdata_q     <= i_cmd_wdata;
                        hsel_q      <= 1'b1;
                        htrans_q    <= HTRANS_NONSEQ;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // The address phase ends when the slave signals ready.
                    if (i_hready) begin
                        hsel_q   <= 1'b0;
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= hwrite_q ? wdata_q : '0;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!i_hready) begin
                        // An ERROR response's first cycle (hready low) lands here
                        // and counts only as a wait cycle.
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d >= TIMEOUT_C) begin
                            stall_q <= 1'b1;
                        end
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= (i_hresp != HRESP_OKAY);
                        rsp_rdata_q <= (!hwrite_q && i_hresp == HRESP_OKAY) ? i_hrdata : '0;
                        rsp_slow_q  <= stall_q;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    // Response fields stay frozen until the consumer takes them.
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        stall_q     <= 1'b0;
                        wait_cnt_q  <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_error = rsp_error_q;
    assign o_rsp_slow  = rsp_slow_q;
    assign o_stall     = stall_q;
    assign o_haddr     = haddr_q;
    assign o_hwrite    = hwrite_q;
    assign o_hsel      = hsel_q;
    assign o_hwdata    = hwdata_q;
    assign o_htrans    = htrans_q;
    assign o_hsize     = 3'b010;   // always word transfers
    assign o_hburst    = 3'b000;   // always SINGLE

endmodule

// File: tb/tb_wav_ahb_csr_cmd_master.sv
// Bench for wav_ahb_csr_cmd_master: directed transfers against a scripted
// slave. A transaction-level model is compared every cycle, and literal
// expectations pin each directed scenario.
module tb_wav_ahb_csr_cmd_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        hreset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error, rsp_slow, stall;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hsel, hready;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;

    int checks = 0;
    int passes = 0;
    bit en = 1'b0;

    wav_ahb_csr_cmd_master #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(T)) dut (
        .i_hclk(clk), .i_hreset(hreset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_error(rsp_error), .o_rsp_slow(rsp_slow), .o_stall(stall),
        .o_haddr(haddr), .o_hwrite(hwrite), .o_hsel(hsel), .o_hwdata(hwdata),
        .o_htrans(htrans), .o_hsize(hsize), .o_hburst(hburst),
        .i_hready(hready), .i_hrdata(hrdata), .i_hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: which phase the single outstanding transfer is in,
    // how many data-phase wait cycles it has seen, and the response it earned.
    int          m_ph;      // 0 idle, 1 address, 2 data, 3 response
    int          m_waits;
    bit          m_w, m_err, m_slow;
    logic [31:0] m_a, m_d, m_rd;

    always @(posedge clk) begin
        if (hreset) begin
            m_ph <= 0; m_waits <= 0; m_w <= 0; m_a <= 0; m_d <= 0;
            m_rd <= 0; m_err <= 0; m_slow <= 0;
        end else begin
            case (m_ph)
                0: if (cmd_valid) begin
                    m_w <= cmd_write; m_a <= cmd_addr; m_d <= cmd_wdata; m_ph <= 1;
                end
                1: if (hready) m_ph <= 2;
                2: if (!hready) m_waits <= m_waits + 1;
                   else begin
                       m_err  <= (hresp != 2'b00);
                       m_rd   <= (m_w || hresp != 2'b00) ? 32'h0 : hrdata;
                       m_slow <= (m_waits >= T);
                       m_ph   <= 3;
                   end
                3: if (rsp_ready) begin m_ph <= 0; m_waits <= 0; end
                default: m_ph <= 0;
            endcase
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (en) begin
            chk("m_cmd_ready", cmd_ready, m_ph == 0);
            chk("m_hsel", hsel, m_ph == 1);
            chk("m_htrans", htrans, (m_ph == 1) ? 2'b10 : 2'b00);
            chk("m_hsize", hsize, 3'b010);
            chk("m_hburst", hburst, 3'b000);
            chk("m_rsp_valid", rsp_valid, m_ph == 3);
            chk("m_stall", stall, (m_ph >= 2) && (m_waits >= T));
            if (m_ph == 1 || m_ph == 2) begin
                chk("m_haddr", haddr, m_a);
                chk("m_hwrite", hwrite, m_w);
            end
            if (m_ph == 2) chk("m_hwdata", hwdata, m_w ? m_d : 32'h0);
            if (m_ph == 3) begin
                chk("m_rsp_rdata", rsp_rdata, m_rd);
                chk("m_rsp_error", rsp_error, m_err);
                chk("m_rsp_slow", rsp_slow, m_slow);
            end
        end
    end

    // One complete command; the slave holds hready low for 'waits' data cycles.
    // exp_stall is the 1-based data cycle where o_stall first shows (-1: never).
    task automatic run_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input bit err, input logic [31:0] rd,
                           input int rsp_delay, input logic [31:0] exp_rdata,
                           input bit exp_err, input bit exp_slow, input int exp_stall);
        int first_stall;
        int dc;
        first_stall = -1;
        dc = 1;
        tick();                                   // c0: offer command
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        hready = 1; hresp = 2'b00;
        @(negedge clk);
        chk("c0_cmd_ready", cmd_ready, 1'b1);
        tick();                                   // c1: address phase
        cmd_valid = 0;
        @(negedge clk);
        chk("c1_htrans", htrans, 2'b10);
        chk("c1_hsel", hsel, 1'b1);
        chk("c1_haddr", haddr, a);
        chk("c1_hwrite", hwrite, w);
        chk("c1_cmd_ready", cmd_ready, 1'b0);
        tick();                                   // c2: first data cycle
        for (int i = 0; i < waits; i++) begin
            hready = 0;
            hresp  = (err && i == waits - 1) ? 2'b01 : 2'b00;
            hrdata = 32'h5555_AAAA;
            @(negedge clk);
            if (i == 0) begin
                chk("c2_htrans", htrans, 2'b00);
                chk("c2_hwdata", hwdata, w ? d : 32'h0);
            end
            chk("data_rsp_valid", rsp_valid, 1'b0);
            if (stall === 1'b1 && first_stall < 0) first_stall = dc;
            tick();
            dc++;
        end
        hready = 1;
        hresp  = err ? 2'b01 : 2'b00;
        hrdata = err ? 32'h1234_5678 : rd;
        @(negedge clk);
        if (waits == 0) begin
            chk("c2_htrans", htrans, 2'b00);
            chk("c2_hwdata", hwdata, w ? d : 32'h0);
        end
        chk("data_rsp_valid", rsp_valid, 1'b0);
        if (stall === 1'b1 && first_stall < 0) first_stall = dc;
        tick();                                   // response cycle c(3+waits)
        hresp = 2'b00; hrdata = 32'hFFFF_0000;
        chk("stall_rise", first_stall, exp_stall);
        for (int k = 0; k <= rsp_delay; k++) begin
            rsp_ready = (k == rsp_delay);
            cmd_valid = (k < rsp_delay);          // must be ignored while busy
            cmd_write = 1; cmd_addr = 32'hBAD0_0000; cmd_wdata = 32'h0000_0BAD;
            @(negedge clk);
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_error", rsp_error, exp_err);
            chk("rsp_slow", rsp_slow, exp_slow);
            chk("rsp_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        rsp_ready = 0; cmd_valid = 0;
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_stall", stall, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_hsel"}, hsel, 1'b0);
        chk({tag, "_htrans"}, htrans, 2'b00);
        chk({tag, "_haddr"}, haddr, 32'h0);
        chk({tag, "_hwrite"}, hwrite, 1'b0);
        chk({tag, "_hwdata"}, hwdata, 32'h0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_error"}, rsp_error, 1'b0);
        chk({tag, "_rsp_slow"}, rsp_slow, 1'b0);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_hsize"}, hsize, 3'b010);
        chk({tag, "_hburst"}, hburst, 3'b000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        hreset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; hready = 1; hrdata = 0; hresp = 0;
        tick(); tick();
        @(negedge clk);
        chk_reset_outputs("reset");
        hreset = 0;
        en = 1;

        // zero-wait write: NONSEQ at c1, hwdata at c2, response at c3
        run_cmd(1, 32'h0000_0004, 32'hA5A5_1234, 0, 0, 32'h0, 0, 32'h0, 0, 0, -1);
        // read with 3 data-phase waits: response at c6
        run_cmd(0, 32'h0000_0008, 32'h0, 3, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, -1);
        // two-cycle ERROR response: error flagged, rdata forced to 0
        run_cmd(0, 32'h0000_000C, 32'h0, 1, 1, 32'h0, 0, 32'h0, 1, 0, -1);
        // 10 waits with TIMEOUT=4: stall visible from data cycle 5, slow latched
        run_cmd(0, 32'h0000_0010, 32'h0, 10, 0, 32'hCAFE_0001, 0, 32'hCAFE_0001, 0, 1, 5);
        // consumer stalls 5 cycles; stray commands must be ignored; low addr bits kept
        run_cmd(1, 32'h0000_0103, 32'h0F0F_F0F0, 0, 0, 32'h0, 5, 32'h0, 0, 0, -1);
        // exactly TIMEOUT waits: stall shows on the completing cycle, slow latched
        run_cmd(0, 32'h0000_0014, 32'h0, 4, 0, 32'h0000_0042, 0, 32'h0000_0042, 0, 1, 5);
        // one fewer than TIMEOUT: never stalls
        run_cmd(0, 32'h0000_0018, 32'h0, 3, 0, 32'h8000_0001, 0, 32'h8000_0001, 0, 0, -1);

        // reset pulsed during the data phase
        tick(); cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h1111_2222;
        tick(); cmd_valid = 0; hready = 1;        // address phase
        tick(); hready = 0;                       // data phase, waiting
        tick(); hready = 0; hreset = 1;
        tick(); hreset = 0; hready = 1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        tick();
        @(negedge clk);
        chk("midrst_no_rsp", rsp_valid, 1'b0);
        run_cmd(0, 32'h0000_0024, 32'h0, 0, 0, 32'h7777_0007, 0, 32'h7777_0007, 0, 0, -1);

        // very long stall: the counter saturates, so the stall must not drop
        run_cmd(0, 32'h0000_0028, 32'h0, 300, 0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 0, 1, 5);

        tick(); tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
